// File: rtl/nwc_ctrl_pkg.sv
// Shared types and helpers for the NWC/NTT controller slice.
`ifndef D_width
`define D_width 8
`endif
`ifndef RADIX_K1
`define RADIX_K1 1
`endif

package nwc_ctrl_pkg;

  // Index width carried by swap_pair_t; the scheduler's DW must match it.
  localparam int unsigned SWAP_IDX_W = `D_width;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } bitrev_sched_state_t;

  typedef struct packed {
    logic [SWAP_IDX_W-1:0] idx;
    logic [SWAP_IDX_W-1:0] rev;
  } swap_pair_t;

  // Reversal width: bits per stage times stage count.
  function automatic int unsigned calc_w(input int unsigned rk, input int unsigned l);
    return rk * l;
  endfunction

endpackage

// File: rtl/bitrev_swap_scheduler_if.sv
// Bit-reverse unit port group plus the swap-pair output stream.
`ifndef D_width
`define D_width 8
`endif

interface bitrev_swap_scheduler_if #(
    parameter int unsigned DW = `D_width
);
    logic [DW-1:0] br_idx;
    logic          br_enable;
    logic [DW-1:0] br_l;
    logic [DW-1:0] br_out;
    logic          pair_valid;
    logic          pair_ready;
    logic [DW-1:0] pair_idx;
    logic [DW-1:0] pair_rev;

    modport master (
        output br_idx, br_enable, br_l,
        input  br_out,
        output pair_valid, pair_idx, pair_rev,
        input  pair_ready
    );

    modport slave (
        input  br_idx, br_enable, br_l,
        output br_out,
        input  pair_valid, pair_idx, pair_rev,
        output pair_ready
    );
endinterface

// File: rtl/bitrev_swap_scheduler_sync_fifo.sv
// Small synchronous FIFO with occupancy count; storage is cleared on reset.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage, pointers and occupancy update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: rtl/bitrev_swap_scheduler.sv
// Sweeps indices through an external registered bit-reverse unit and emits
// (idx, rev) swap pairs on a valid/ready stream.
`ifndef D_width
`define D_width 8
`endif
`ifndef RADIX_K1
`define RADIX_K1 1
`endif

module bitrev_swap_scheduler
  import nwc_ctrl_pkg::*;
#(
  parameter int unsigned DW         = `D_width,
  parameter int unsigned RK         = `RADIX_K1,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DW-1:0]           l_cfg,
  input  logic                    skip_self,
  bitrev_swap_scheduler_if.master bus,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  bitrev_sched_state_t state;
  bitrev_sched_state_t state_next;

  logic [DW-1:0] l_q;
  logic          skip_q;
  logic [DW:0]   cnt;
  logic          inflight;
  logic [DW-1:0] idx_last;

  logic [DW+3:0] w_start;
  logic [DW+3:0] w_run;
  logic          cfg_ok;
  logic [DW:0]   last_idx;

  logic          issue;
  logic          credit;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  swap_pair_t    push_pair;
  swap_pair_t    head_pair;

  assign w_start  = (DW+4)'(calc_w(RK, 32'(l_cfg)));
  assign w_run    = (DW+4)'(calc_w(RK, 32'(l_q)));
  assign cfg_ok   = (w_start != '0) && (w_start <= (DW+4)'(DW));
  assign last_idx = ((DW+1)'(1) << w_run) - (DW+1)'(1);

  assign pop = !fifo_empty && bus.pair_ready;

  // A slot freed by this cycle's pop counts as credit so a continuously
  // ready consumer sees one pair per cycle with only two FIFO entries;
  // occupancy plus in-flight still never exceeds FIFO_DEPTH.
  assign credit = (32'(fifo_count) + 32'(inflight)) < (FIFO_DEPTH + 32'(pop));

  assign push          = inflight && !(skip_q && (idx_last >= bus.br_out));
  assign push_pair.idx = idx_last;
  assign push_pair.rev = bus.br_out;

  assign bus.br_enable  = issue;
  assign bus.br_idx     = issue ? cnt[DW-1:0] : idx_last;
  assign bus.br_l       = l_q;
  assign bus.pair_valid = !fifo_empty;
  assign bus.pair_idx   = head_pair.idx;
  assign bus.pair_rev   = head_pair.rev;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && cfg_ok) state_next = ISSUE;
      ISSUE:   if (issue && (cnt == last_idx)) state_next = DRAIN;
      DRAIN:   if (!inflight && fifo_empty) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-dependent outputs.
  always_comb begin
    issue = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE: ;
      ISSUE: begin
        busy  = 1'b1;
        issue = credit;
      end
      DRAIN: busy = 1'b1;
      FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Sweep configuration, issue counter and in-flight tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_q      <= '0;
      skip_q   <= 1'b0;
      cfg_err  <= 1'b0;
      cnt      <= '0;
      inflight <= 1'b0;
      idx_last <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        idx_last <= cnt[DW-1:0];
        cnt      <= cnt + (DW+1)'(1);
      end
      if ((state == IDLE) && start) begin
        l_q     <= l_cfg;
        skip_q  <= skip_self;
        cnt     <= '0;
        cfg_err <= !cfg_ok;
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(swap_pair_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_pair),
    .pop       (pop),
    .pop_data  (head_pair),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_bitrev_swap_scheduler.sv
// Directed bench for bitrev_swap_scheduler with a queue-based pair scoreboard.
module tb_bitrev_swap_scheduler;
    localparam int unsigned DW    = 8;
    localparam int unsigned RK_TB = 1;
    localparam int unsigned DEPTH = 2;

    typedef struct {
        int unsigned idx;
        int unsigned rev;
    } exp_pair_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] l_cfg;
    logic          skip_self;
    logic          busy;
    logic          done;
    logic          cfg_err;

    bitrev_swap_scheduler_if #(.DW(DW)) bus ();

    bitrev_swap_scheduler #(
        .DW         (DW),
        .RK         (RK_TB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .l_cfg     (l_cfg),
        .skip_self (skip_self),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    int unsigned start_cyc = 0;
    int unsigned pops = 0;
    int unsigned issued = 0;
    int unsigned done_cnt = 0;
    int unsigned first_pop_cyc = 0;
    int unsigned last_pop_cyc = 0;
    int unsigned done_cyc = 0;
    bit          chk_credit = 1'b0;
    bit          prev_stall = 1'b0;
    logic [DW-1:0] prev_idx = '0;
    logic [DW-1:0] prev_rev = '0;
    exp_pair_t   sb[$];
    int unsigned l3_rev[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    function automatic int unsigned rev_ref(input int unsigned v, input int unsigned w);
        int unsigned r = 0;
        for (int unsigned b = 0; b < w; b++) begin
            if (((v >> b) & 32'd1) != 0) r = r | (32'd1 << (w - 1 - b));
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    // External registered bit-reverse unit.
    always @(posedge clk) begin
        if (bus.br_enable) bus.br_out <= DW'(rev_ref(32'(bus.br_idx), RK_TB * 32'(bus.br_l)));
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: scoreboard pops, stall stability, credit bound, done.
    always @(negedge clk) begin : mon
        exp_pair_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(bus.pair_valid), 1);
                check("stall_idx", 32'(bus.pair_idx), 32'(prev_idx));
                check("stall_rev", 32'(bus.pair_rev), 32'(prev_rev));
            end
            if (bus.br_enable) issued++;
            if (bus.pair_valid && bus.pair_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_pair", 32'(bus.pair_idx) + 32'd1000, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("pair_idx", 32'(bus.pair_idx), e.idx);
                    check("pair_rev", 32'(bus.pair_rev), e.rev);
                end
                if (pops == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                pops++;
            end
            if (chk_credit && bus.br_enable) check("credit_ahead", 32'(issued - pops <= DEPTH), 1);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_busy", 32'(busy), 1);
                check("done_drained", 32'(sb.size()), 0);
            end
            prev_stall = bus.pair_valid && !bus.pair_ready;
            prev_idx   = bus.pair_idx;
            prev_rev   = bus.pair_rev;
        end
    end

    task automatic push_l3(input bit skip);
        for (int unsigned i = 0; i < 8; i++) begin
            if (!skip || (i < l3_rev[i])) sb.push_back('{idx: i, rev: l3_rev[i]});
        end
    endtask

    task automatic push_gen(input int unsigned w);
        for (int unsigned i = 0; i < (32'd1 << w); i++) sb.push_back('{idx: i, rev: rev_ref(i, w)});
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1-0-0-1. poke != 0 pulses start mid-sweep.
    task automatic run_sweep(input int unsigned l, input bit skip, input int unsigned mode,
                             input int unsigned poke);
        int unsigned d0;
        int unsigned t;
        d0     = done_cnt;
        pops   = 0;
        issued = 0;
        chk_credit = !skip;
        @(posedge clk); #1;
        l_cfg = DW'(l); skip_self = skip; start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        t = 0;
        while (done_cnt == d0 && t < 400) begin
            bus.pair_ready = (mode == 1) ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
            if (poke != 0 && t == poke) begin
                start = 1'b1; l_cfg = DW'(l + 1); skip_self = !skip;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0; bus.pair_ready = 1'b1; chk_credit = 1'b0;
        check("sweep_done_count", done_cnt - d0, 1);
        check("busy_after_done", 32'(busy), 0);
        check("done_one_cycle", 32'(done), 0);
        check("sb_empty", 32'(sb.size()), 0);
    endtask

    task automatic bad_start(input int unsigned l);
        int unsigned d0;
        d0 = done_cnt; issued = 0;
        @(posedge clk); #1;
        l_cfg = DW'(l); skip_self = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("cfg_err_set", 32'(cfg_err), 1);
        check("cfg_busy", 32'(busy), 0);
        repeat (4) @(posedge clk);
        #1;
        check("cfg_err_sticky", 32'(cfg_err), 1);
        check("cfg_no_issue", issued, 0);
        check("cfg_no_done", done_cnt - d0, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit found;
        int unsigned d0;
        rst = 1'b1; start = 1'b0; l_cfg = '0; skip_self = 1'b0; bus.pair_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);
        check("rst_br_enable", 32'(bus.br_enable), 0);
        check("rst_pair_valid", 32'(bus.pair_valid), 0);
        check("rst_br_idx", 32'(bus.br_idx), 0);
        rst = 1'b0;

        // l=3, full throughput
        push_l3(1'b0);
        run_sweep(3, 1'b0, 0, 0);
        check("t1_pops", pops, 8);
        check("t1_consecutive", last_pop_cyc - first_pop_cyc, 7);
        check("t1_latency", first_pop_cyc - start_cyc, 3);
        check("t1_done_after_last", 32'(done_cyc > last_pop_cyc), 1);

        // l=3, skip self/duplicate pairs
        push_l3(1'b1);
        run_sweep(3, 1'b1, 0, 0);
        check("t2_pops", pops, 2);

        // W=4 with backpressure
        push_gen(4);
        run_sweep(4, 1'b0, 1, 0);
        check("t3_pops", pops, 16);

        // illegal configurations, each cleared by a legal start
        bad_start(0);
        sb.push_back('{idx: 0, rev: 0});
        sb.push_back('{idx: 1, rev: 1});
        run_sweep(1, 1'b0, 0, 0);
        check("cfg_err_cleared_1", 32'(cfg_err), 0);
        bad_start(DW + 1);
        push_gen(2);
        run_sweep(2, 1'b0, 0, 0);
        check("cfg_err_cleared_2", 32'(cfg_err), 0);

        // reset mid-sweep at counter 5
        push_gen(4);
        d0 = done_cnt;
        @(posedge clk); #1;
        l_cfg = DW'(4); skip_self = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk); #1;
            if (bus.br_enable && (bus.br_idx == DW'(5))) found = 1'b1;
        end
        check("reach_idx5", 32'(found), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_br_enable", 32'(bus.br_enable), 0);
        check("mid_rst_br_idx", 32'(bus.br_idx), 0);
        check("mid_rst_br_l", 32'(bus.br_l), 0);
        check("mid_rst_pair_valid", 32'(bus.pair_valid), 0);
        check("mid_rst_pair_idx", 32'(bus.pair_idx), 0);
        check("mid_rst_pair_rev", 32'(bus.pair_rev), 0);
        repeat (5) @(posedge clk);
        #1;
        check("mid_rst_no_done", done_cnt - d0, 0);
        push_l3(1'b0);
        run_sweep(3, 1'b0, 0, 0);
        check("restart_pops", pops, 8);

        // start pulsed while busy
        push_l3(1'b0);
        run_sweep(3, 1'b0, 0, 3);
        check("poke_pops", pops, 8);
        check("poke_br_l", 32'(bus.br_l), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
